// File: rtl/imm_ext_stage.sv
// Decode-stage immediate extender and ID/EX register; 1-cycle latency, full throughput.
// Stalls upstream while the held output is not consumed; flush kills held and incoming work.
module imm_ext_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [1:0]       iControl,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_imm,
  output logic             out_use_imm,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [1:0] IC_NONE = 2'b00;
  localparam logic [1:0] IC_SEXT = 2'b01;
  localparam logic [1:0] IC_ZEXT = 2'b10;
  localparam logic [1:0] IC_BAD  = 2'b11;

  logic        accept;
  logic        load;
  logic        bad_acc;
  logic [31:0] imm_nxt;
  logic        use_nxt;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && (iControl != IC_BAD);
  assign bad_acc  = accept && (iControl == IC_BAD);

  always_comb begin
    imm_nxt = 32'h0;
    use_nxt = 1'b0;
    case (iControl)
      IC_SEXT: begin
        imm_nxt = {{16{instr[15]}}, instr[15:0]};
        use_nxt = 1'b1;
      end
      IC_ZEXT: begin
        imm_nxt = {16'h0, instr[15:0]};
        use_nxt = 1'b1;
      end
      IC_NONE: begin
        imm_nxt = 32'h0;
        use_nxt = 1'b0;
      end
      default: begin
        imm_nxt = 32'h0;
        use_nxt = 1'b0;
      end
    endcase
  end

  // An unsupported accept drains the slot just like a consume does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (bad_acc || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_instr   <= 32'h0;
      out_imm     <= 32'h0;
      out_use_imm <= 1'b0;
    end else if (load) begin
      out_instr   <= instr;
      out_imm     <= imm_nxt;
      out_use_imm <= use_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      illegal <= bad_acc;
      if (bad_acc && (illegal_cnt != {CNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Randomized and directed checks of imm_ext_stage against a transaction-level reference model.
module tb_imm_ext_stage;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = 32'h0;
  logic [1:0]       iControl = 2'b00;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [31:0]      out_imm;
  logic             out_use_imm;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_imm;
  logic        m_use;
  logic        m_ill;
  int          m_cnt;

  imm_ext_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .iControl(iControl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_imm(out_imm), .out_use_imm(out_use_imm),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // immediate value from the field meaning, using plain arithmetic
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [1:0] ic);
    logic [31:0] low;
    low = ins & 32'h0000FFFF;
    if (ic == 2'b01) return (low >= 32'h8000) ? low - 32'h10000 : low;
    if (ic == 2'b10) return low;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_instr = 32'h0; m_imm = 32'h0; m_use = 1'b0;
    m_ill = 1'b0; m_cnt = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_instr"}, out_instr, m_instr);
    chk({tag, ".out_imm"}, out_imm, m_imm);
    chk({tag, ".out_use_imm"}, 32'(out_use_imm), 32'(m_use));
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
    chk({tag, ".illegal_cnt"}, 32'(illegal_cnt), 32'(m_cnt));
  endtask

  // One clock: drive, check in_ready, clock, advance model, check outputs.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [1:0] ic,
                     input logic fl, input logic rd, input string tag);
    logic exp_rdy;
    in_valid = v; instr = ins; iControl = ic; flush = fl; out_ready = rd;
    #1;
    exp_rdy = !fl && (!m_valid || rd);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    m_ill = 1'b0;
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && exp_rdy) begin
      if (ic == 2'b11) begin
        m_valid = 1'b0;
        m_ill = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_valid = 1'b1;
        m_instr = ins;
        m_imm   = ref_imm(ins, ic);
        m_use   = (ic != 2'b00);
      end
    end else if (rd) begin
      m_valid = 1'b0;
    end
    #2;
    check_outs(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    check_outs("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    // sign-extend (lw)
    cyc(1'b1, 32'h8C41FFFC, 2'b01, 1'b0, 1'b1, "lw");
    chk("lw.imm_const", out_imm, 32'hFFFFFFFC);
    chk("lw.use_const", 32'(out_use_imm), 32'd1);

    // zero-extend then R-type, back to back
    cyc(1'b1, 32'h34428000, 2'b10, 1'b0, 1'b1, "ori");
    chk("ori.imm_const", out_imm, 32'h00008000);
    cyc(1'b1, 32'h00430820, 2'b00, 1'b0, 1'b1, "add");
    chk("add.valid_const", 32'(out_valid), 32'd1);
    chk("add.imm_const", out_imm, 32'h0);

    // backpressure
    cyc(1'b1, 32'h8C220010, 2'b01, 1'b0, 1'b1, "bpA");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h3463ABCD, 2'b10, 1'b0, 1'b0, "bpStall");
      chk("bpStall.hold_A", out_instr, 32'h8C220010);
    end
    cyc(1'b1, 32'h3463ABCD, 2'b10, 1'b0, 1'b1, "bpDrain");
    chk("bpDrain.B_out", out_instr, 32'h3463ABCD);
    chk("bpDrain.B_imm", out_imm, 32'h0000ABCD);

    // unsupported instruction
    cyc(1'b1, 32'hFC000000, 2'b11, 1'b0, 1'b1, "bad");
    chk("bad.illegal_const", 32'(illegal), 32'd1);
    cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, "bad2");
    chk("bad2.cnt_const", 32'(illegal_cnt), 32'd1);

    // flush while stalled
    cyc(1'b1, 32'h20A5FF00, 2'b01, 1'b0, 1'b0, "flSetup");
    cyc(1'b1, 32'h34C60077, 2'b10, 1'b1, 1'b0, "flush");
    chk("flush.valid_const", 32'(out_valid), 32'd0);
    cyc(1'b1, 32'h34C60077, 2'b10, 1'b0, 1'b0, "postFlush");
    chk("postFlush.instr_const", out_instr, 32'h34C60077);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0), "rand");
    end

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, $urandom, 2'b11, 1'b0, 1'($urandom), "sat");
    end
    chk("sat.cnt_const", 32'(illegal_cnt), 32'd255);

    // clean reset, then build out_valid=1 with illegal_cnt=5
    reset_n = 1'b0;
    #1;
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hFC000000, 2'b11, 1'b0, 1'b1, "pre");
    cyc(1'b1, 32'h8C41000C, 2'b01, 1'b0, 1'b0, "preLoad");
    chk("preLoad.cnt_const", 32'(illegal_cnt), 32'd5);

    // async reset between edges
    in_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outs("arst");
    chk("arst.valid_const", 32'(out_valid), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    check_outs("arstIdle");
    cyc(1'b1, 32'h34421234, 2'b10, 1'b0, 1'b1, "arstFirst");
    chk("arstFirst.valid_const", 32'(out_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
